// File: rtl/i2f_pkg.sv
// Shared constants, S1 payload type and float packing helper for int2fp_arbiter.
package i2f_pkg;

   localparam int unsigned INT_W    = 32;
   localparam int unsigned EXP_W    = 8;
   localparam int unsigned FRAC_W   = 23;
   localparam int unsigned EXP_BIAS = 127;
   localparam int unsigned POS_W    = $clog2(INT_W);
   // Widest requester tag (NREQ <= 8); narrower tags use the low bits.
   localparam int unsigned ID_W_MAX = 3;

   typedef struct packed {
      logic                sign;
      logic [INT_W-1:0]    mag;
      logic [ID_W_MAX-1:0] id;
   } s1_payload_t;

   function automatic logic [INT_W-1:0] pack_fp(
      input logic              sign,
      input logic [EXP_W-1:0]  expo,
      input logic [FRAC_W-1:0] frac
   );
      return {sign, expo, frac};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from last+1 upward, pointer moves only on an accepted transfer.
module rr_arbiter #(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NREQ-1:0] req_i,
   input  logic            advance_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDW-1:0]  last_o
);

   logic [IDW-1:0] last_q, last_d;
   logic [IDW-1:0] idx;
   logic           found;

   // First valid requester after the last granted one wins.
   always_comb begin
      grant_o = '0;
      last_d  = last_q;
      idx     = '0;
      found   = 1'b0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = IDW'((32'(last_q) + k) % NREQ);
         if (!found && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            last_d       = idx;
            found        = 1'b1;
         end
      end
   end

   // Pointer register; holds across stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= IDW'(NREQ - 1);
      end else if (advance_i) begin
         last_q <= last_d;
      end
   end

   assign last_o = last_q;

endmodule

// File: rtl/int2fp_arbiter.sv
// Shared int32 -> IEEE-754 single converter behind a round-robin arbiter.
// Two-stage stall pipeline: S1 captures sign/magnitude, S2 normalizes and is the output register.
// Define I2F_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module int2fp_arbiter
   import i2f_pkg::*;
#(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [32*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic [IDW-1:0]    out_id,
   output logic              busy
);

   logic [NREQ-1:0]     grant;
   logic [IDW-1:0]      rr_last_unused;
   logic                s1_valid_q;
   s1_payload_t         s1_q, s1_d;
   logic                s2_valid_q;
   logic [INT_W-1:0]    s2_data_q;
   logic [IDW-1:0]      s2_id_q;
   logic                s1_adv, s1_open, accept;
   logic [INT_W-1:0]    sel_data;
   logic [ID_W_MAX-1:0] sel_id;
   logic [POS_W-1:0]    msb_pos, shamt;
   logic [FRAC_W-1:0]   frac;
   logic [EXP_W-1:0]    expo;
   logic [INT_W-1:0]    fp_d;
`ifdef I2F_RNE_EN
   logic [7:0]          grs;
`endif

   assign s1_adv    = !s2_valid_q || out_ready;
   assign s1_open   = !s1_valid_q || s1_adv;
   assign req_ready = (s1_open && reset_n) ? grant : '0;
   assign accept    = |req_ready;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_i     (req_valid),
      .advance_i (accept),
      .grant_o   (grant),
      .last_o    (rr_last_unused)
   );

   // Select granted requester's word and split into sign/magnitude.
   always_comb begin
      sel_data = '0;
      sel_id   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_data = req_data[32*i +: 32];
            sel_id   = ID_W_MAX'(i);
         end
      end
      s1_d.sign = sel_data[INT_W-1];
      s1_d.mag  = sel_data[INT_W-1] ? -sel_data : sel_data;
      s1_d.id   = sel_id;
   end

   // S1 capture register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
      end else if (s1_open) begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_q <= s1_d;
         end
      end
   end

   // Normalize S1 magnitude: MSB position sets exponent, next 23 bits form the fraction.
   always_comb begin
      msb_pos = '0;
      for (int unsigned i = 0; i < INT_W; i++) begin
         if (s1_q.mag[i]) begin
            msb_pos = POS_W'(i);
         end
      end
      shamt = POS_W'(INT_W - 1) - msb_pos;
      frac  = FRAC_W'((s1_q.mag << shamt) >> (INT_W - FRAC_W - 1));
      expo  = EXP_W'(EXP_BIAS) + EXP_W'(msb_pos);
`ifdef I2F_RNE_EN
      grs = 8'(s1_q.mag << shamt);
      if (grs[7] && ((grs[6:0] != '0) || frac[0])) begin
         if (&frac) begin
            frac = '0;
            expo = expo + EXP_W'(1);
         end else begin
            frac = frac + FRAC_W'(1);
         end
      end
`endif
      fp_d = (s1_q.mag == '0) ? '0 : pack_fp(s1_q.sign, expo, frac);
   end

   // S2 output register; holds data while stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_id_q    <= '0;
      end else if (s1_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_data_q <= fp_d;
            s2_id_q   <= IDW'(s1_q.id);
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_id    = s2_id_q;
   assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_int2fp_arbiter.sv
// Directed self-checking bench for int2fp_arbiter (NREQ = 4).
module tb_int2fp_arbiter;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [3:0]   req_valid = '0;
   logic [127:0] req_data = '0;
   logic [3:0]   req_ready;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [31:0]  out_data;
   logic [1:0]   out_id;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int accepts;

`ifdef I2F_RNE_EN
   localparam logic [31:0] EXP_0103 = 32'h4B800002;
   localparam logic [31:0] EXP_7FFF = 32'h4F000000;
`else
   localparam logic [31:0] EXP_0103 = 32'h4B800001;
   localparam logic [31:0] EXP_7FFF = 32'h4EFFFFFF;
`endif

   logic [31:0] rr_fp [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
   logic [31:0] sp_fp [4] = '{32'h3F800000, 32'h40000000, 32'h41100000, 32'h40800000};
   logic [3:0]  sp_valid [9] = '{4'b0100, 4'b0100, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 4'b0000};
   logic [3:0]  sp_ready [9] = '{4'b0100, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
   int          sp_id    [9] = '{-1, -1, 2, 2, 3, 1, 2, 3, -1};

   always #5 clk = ~clk;

   int2fp_arbiter #(.NREQ(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic setd(input int i, input logic [31:0] v);
      req_data[32*i +: 32] = v;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, with a requester already asserting valid
      req_valid = 4'b0001;
      setd(0, 32'd7);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_id", 32'(out_id), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);

      // Basic conversion: 7, -1, 0 from requester 0
      @(negedge clk); reset_n = 1'b1; #1;
      chk("basic_ready_first", 32'(req_ready), 32'h1);
      @(negedge clk); setd(0, 32'hFFFFFFFF); #1;
      chk("basic_ready_s1full", 32'(req_ready), 32'h1);
      chk("basic_not_yet_valid", 32'(out_valid), 32'h0);
      chk("basic_busy", 32'(busy), 32'h1);
      @(negedge clk); setd(0, 32'h0); #1;
      chk("basic_valid_7", 32'(out_valid), 32'h1);
      chk("basic_data_7", out_data, 32'h40E00000);
      chk("basic_id_7", 32'(out_id), 32'h0);
      @(negedge clk); req_valid = 4'b0000; #1;
      chk("basic_data_m1", out_data, 32'hBF800000);
      @(negedge clk); #1;
      chk("basic_valid_0", 32'(out_valid), 32'h1);
      chk("basic_data_0", out_data, 32'h00000000);
      @(negedge clk); #1;
      chk("basic_drained_valid", 32'(out_valid), 32'h0);
      chk("basic_drained_busy", 32'(busy), 32'h0);

      // Extremes: -2^31, rounding case, INT_MAX
      req_valid = 4'b0001; setd(0, 32'h80000000);
      @(negedge clk); setd(0, 32'h01000003);
      @(negedge clk); setd(0, 32'h7FFFFFFF); #1;
      chk("ext_min", out_data, 32'hCF000000);
      @(negedge clk); req_valid = 4'b0000; #1;
      chk("ext_0103", out_data, EXP_0103);
      @(negedge clk); #1;
      chk("ext_7fff", out_data, EXP_7FFF);
      chk("ext_id", 32'(out_id), 32'h0);

      // Mid-operation reset with both stages full
      out_ready = 1'b0; req_valid = 4'b0001; setd(0, 32'd5);
      @(negedge clk); #1;
      chk("mrst_full_ready", 32'(req_ready), 32'h0);
      chk("mrst_full_valid", 32'(out_valid), 32'h1);
      chk("mrst_full_busy", 32'(busy), 32'h1);
      chk("mrst_stall_data", out_data, EXP_7FFF);
      reset_n = 1'b0; #1;
      chk("mrst_out_valid", 32'(out_valid), 32'h0);
      chk("mrst_busy", 32'(busy), 32'h0);
      chk("mrst_out_data", out_data, 32'h0);
      chk("mrst_ready", 32'(req_ready), 32'h0);
      req_valid = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) setd(i, 32'(i + 1));

      // Round-robin fairness after release: grants 0,1,2,3,0,...
      @(negedge clk); reset_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k == 8) req_valid = 4'b0000;
         #1;
         chk($sformatf("rr_ready_%0d", k), 32'(req_ready), (k < 8) ? (32'h1 << (k % 4)) : 32'h0);
         if (k >= 2) begin
            chk($sformatf("rr_valid_%0d", k), 32'(out_valid), 32'h1);
            chk($sformatf("rr_id_%0d", k), 32'(out_id), 32'((k - 2) % 4));
            chk($sformatf("rr_data_%0d", k), out_data, rr_fp[(k - 2) % 4]);
         end else begin
            chk($sformatf("rr_valid_%0d", k), 32'(out_valid), 32'h0);
         end
         @(negedge clk);
      end
      #1;
      chk("rr_drained", 32'(busy), 32'h0);

      // Backpressure: 10 stalled cycles, exactly two accepts
      out_ready = 1'b0; req_valid = 4'b1111; accepts = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (req_ready != 4'b0000) accepts++;
         chk($sformatf("bp_ready_%0d", c), 32'(req_ready), (c == 0) ? 32'h1 : (c == 1) ? 32'h2 : 32'h0);
         if (c >= 2) begin
            chk($sformatf("bp_valid_%0d", c), 32'(out_valid), 32'h1);
            chk($sformatf("bp_id_%0d", c), 32'(out_id), 32'h0);
            chk($sformatf("bp_data_%0d", c), out_data, 32'h3F800000);
         end
         @(negedge clk);
      end
      chk("bp_accepts", 32'(accepts), 32'd2);
      out_ready = 1'b1; #1;
      chk("bp_release_grant", 32'(req_ready), 32'h4);
      @(negedge clk); #1;
      chk("bp_out1_id", 32'(out_id), 32'h1);
      chk("bp_out1_data", out_data, 32'h40000000);
      chk("bp_grant3", 32'(req_ready), 32'h8);
      @(negedge clk); req_valid = 4'b0000; #1;
      chk("bp_out2_id", 32'(out_id), 32'h2);
      chk("bp_out2_data", out_data, 32'h40400000);
      @(negedge clk); #1;
      chk("bp_out3_id", 32'(out_id), 32'h3);
      chk("bp_out3_data", out_data, 32'h40800000);
      @(negedge clk); #1;
      chk("bp_drained_valid", 32'(out_valid), 32'h0);

      // Sparse traffic: requester 2 alone, then 1 and 3 join
      setd(2, 32'd9);
      for (int s = 0; s < 9; s++) begin
         req_valid = sp_valid[s];
         #1;
         chk($sformatf("sp_ready_%0d", s), 32'(req_ready), 32'(sp_ready[s]));
         if (sp_id[s] >= 0) begin
            chk($sformatf("sp_valid_%0d", s), 32'(out_valid), 32'h1);
            chk($sformatf("sp_id_%0d", s), 32'(out_id), 32'(sp_id[s]));
            chk($sformatf("sp_data_%0d", s), out_data, sp_fp[sp_id[s]]);
         end else begin
            chk($sformatf("sp_valid_%0d", s), 32'(out_valid), 32'h0);
         end
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
